bm_uniform_packer: RTL and testbench

- Sits directly downstream of the Tausworthe uniform generator and directly upstream of the Box-Muller log/sqrt and sin/cos stages.
- Collects consecutive 32-bit uniform words in pairs and builds a 48-bit u0 (log path) and a 16-bit u1 (trig path).
- Computes the leading-zero count of u0 for log range reduction.
- Buffers results in a small FIFO with a valid/ready output. The generator free-runs and cannot be stalled, so when the FIFO is full, whole pairs are dropped and counted.

---
 rtl/bm_uniform_packer.sv | 199 +++++++++++++++++++
 tb/tb_bm_uniform_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_uniform_packer.sv
`default_nettype none
// ============================================================================
// Module   : bm_uniform_packer
// Purpose  : Pairs consecutive 32-bit uniform words into a 48-bit u0 (log
//            path) and a 16-bit u1 (trig path). It also computes the leading-
//            zero count of u0 and buffers {u0,u1,lzc} in a small FIFO with a
//            valid/ready output. The upstream generator cannot be stalled,
//            so whole pairs are dropped and counted when the FIFO is full.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            in_valid   - in_data carries a new word this cycle
//            in_data    - 32-bit uniform word
//            out_valid  - head entry valid
//            out_ready  - consumer accepts head entry
//            out_u0     - head u0 (48 bit)
//            out_u1     - head u1 (16 bit)
//            out_lzc    - leading zeros of out_u0 (0..48)
//            drop_cnt   - saturating count of discarded pairs
// Options  : BM_ZERO_GUARD_EN - when defined, u0==0 is stored as u0=1
//            (lzc=47) so the log stage never sees zero.
// Revision : 1.0 - initial release
// ============================================================================
module bm_uniform_packer #(
    parameter int FIFO_DEPTH = 2,
    parameter int DROP_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [47:0]       out_u0,
    output logic [15:0]       out_u1,
    output logic [5:0]        out_lzc,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         hi_q, hi_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic [47:0]         head_u0_q, head_u0_d;
    logic [15:0]         head_u1_q, head_u1_d;
    logic [5:0]          head_lzc_q, head_lzc_d;

    logic [47:0]         mem_u0_q  [FIFO_DEPTH];
    logic [15:0]         mem_u1_q  [FIFO_DEPTH];
    logic [5:0]          mem_lzc_q [FIFO_DEPTH];

    logic                w_pair;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [47:0]         w_u0_raw;
    logic [47:0]         w_u0;
    logic [5:0]          w_lzc;
    logic                w_bypass;

    // Highest set bit wins because later loop iterations overwrite earlier ones.
    function automatic logic [5:0] f_lzc(input logic [47:0] v);
        logic [5:0] n;
        n = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (v[i]) begin
                n = 6'(47 - i);
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Pair formation
    // ------------------------------------------------------------------
    assign w_u0_raw = {hi_q, in_data[31:16]};

`ifdef BM_ZERO_GUARD_EN
    assign w_u0 = (w_u0_raw == 48'd0) ? 48'h000000000001 : w_u0_raw;
`else
    assign w_u0 = w_u0_raw;
`endif

    // Computed on the (possibly guarded) value, so a guarded zero yields 47.
    assign w_lzc  = f_lzc(w_u0);

    assign w_pair = (state_q == WAIT_LO) && in_valid;
    assign w_pop  = (count_q != '0) && out_ready;
    // count never exceeds depth, so "not below depth" means full; a same-cycle
    // pop frees the slot being written.
    assign w_push = w_pair && ((count_q < C_DEPTH) || w_pop);
    assign w_drop = w_pair && !((count_q < C_DEPTH) || w_pop);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        case (state_q)
            WAIT_HI: begin
                if (in_valid) begin
                    hi_d    = in_data;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (in_valid) begin
                    state_d = WAIT_HI;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping and head register
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(w_push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(w_pop);
        count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

        drop_d     = drop_q;
        if (w_drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end

        // The next head slot can only coincide with the slot being written
        // when the FIFO drains to empty this cycle; forward the new entry.
        w_bypass   = w_push && (rd_ptr_d == wr_ptr_q);

        head_u0_d  = head_u0_q;
        head_u1_d  = head_u1_q;
        head_lzc_d = head_lzc_q;
        if (count_d != '0) begin
            if (w_bypass) begin
                head_u0_d  = w_u0;
                head_u1_d  = in_data[15:0];
                head_lzc_d = w_lzc;
            end else begin
                head_u0_d  = mem_u0_q[rd_ptr_d];
                head_u1_d  = mem_u1_q[rd_ptr_d];
                head_lzc_d = mem_lzc_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= WAIT_HI;
            hi_q       <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            head_u0_q  <= 48'd0;
            head_u1_q  <= 16'd0;
            head_lzc_q <= 6'd0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            head_u0_q  <= head_u0_d;
            head_u1_q  <= head_u1_d;
            head_lzc_q <= head_lzc_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            mem_u0_q[wr_ptr_q]  <= w_u0;
            mem_u1_q[wr_ptr_q]  <= in_data[15:0];
            mem_lzc_q[wr_ptr_q] <= w_lzc;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_u0    = head_u0_q;
    assign out_u1    = head_u1_q;
    assign out_lzc   = head_lzc_q;
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_bm_uniform_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bm_uniform_packer
// Purpose  : Self-checking bench for bm_uniform_packer. A queue-based
//            reference model tracks pairing, FIFO contents and drops; vector
//            tables and hand sequences add fixed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bm_uniform_packer;

    localparam int DEPTH  = 2;
    localparam int DMAX   = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b0;
    logic        r2_ready = 1'b0;

    logic        out_valid;
    logic [47:0] out_u0;
    logic [15:0] out_u1;
    logic [5:0]  out_lzc;
    logic [15:0] drop_cnt;

    logic        out_valid2;
    logic [47:0] out_u0_2;
    logic [15:0] out_u1_2;
    logic [5:0]  out_lzc2;
    logic [3:0]  drop_cnt2;

    always #5 clk = ~clk;

    bm_uniform_packer #(.FIFO_DEPTH(DEPTH), .DROP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_u0(out_u0),
        .out_u1(out_u1), .out_lzc(out_lzc), .drop_cnt(drop_cnt)
    );

    // Deeper FIFO with a narrow drop counter, never read, to reach saturation.
    bm_uniform_packer #(.FIFO_DEPTH(4), .DROP_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(r2_ready), .out_u0(out_u0_2),
        .out_u1(out_u1_2), .out_lzc(out_lzc2), .drop_cnt(drop_cnt2)
    );

    typedef struct packed {
        logic [47:0] u0;
        logic [15:0] u1;
        logic [5:0]  lzc;
    } ent_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [47:0] u0;
        logic [15:0] u1;
        logic [5:0]  lzc;
    } vec_t;

    ent_t        mq[$];
    logic        m_have_hi;
    logic [31:0] m_hi;
    int unsigned m_drop;
    ent_t        m_last;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] hi, input logic [31:0] lo);
        ent_t e;
        logic [47:0] v;
        int len;
        e.u0 = {hi, lo[31:16]};
`ifdef BM_ZERO_GUARD_EN
        if (e.u0 == 48'd0) e.u0 = 48'd1;
`endif
        e.u1 = lo[15:0];
        v = e.u0;
        len = 0;
        while (v != 48'd0) begin
            v = v >> 1;
            len++;
        end
        e.lzc = 6'(48 - len);
        return e;
    endfunction

    // Applies the rules for one clock edge using the inputs now on the pins.
    task automatic model_step();
        int  sz;
        logic pop;
        if (!rst_n) begin
            mq.delete();
            m_have_hi = 1'b0;
            m_hi      = 32'd0;
            m_drop    = 0;
            m_last    = '0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (in_valid) begin
                if (!m_have_hi) begin
                    m_hi      = in_data;
                    m_have_hi = 1'b1;
                end else begin
                    m_have_hi = 1'b0;
                    if ((sz < DEPTH) || pop) mq.push_back(mk(m_hi, in_data));
                    else if (m_drop != DMAX) m_drop++;
                end
            end
            if (mq.size() > 0) m_last = mq[0];
        end
    endtask

    task automatic model_check();
        chk("m_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("m_drop",  64'(drop_cnt),  64'(m_drop));
        chk("m_u0",    64'(out_u0),    64'(m_last.u0));
        chk("m_u1",    64'(out_u1),    64'(m_last.u1));
        chk("m_lzc",   64'(out_lzc),   64'(m_last.lzc));
    endtask

    task automatic cycle(input logic r, input logic v, input logic [31:0] d, input logic rdy);
        rst_n     = r;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    vec_t tbl[8];

    initial begin
        logic [31:0] d;
        tbl[0] = '{32'h12345678, 32'h9ABCDEF0, 48'h123456789ABC, 16'hDEF0, 6'd3};
        tbl[1] = '{32'h00000000, 32'h0001FFFF, 48'h000000000001, 16'hFFFF, 6'd47};
`ifdef BM_ZERO_GUARD_EN
        tbl[2] = '{32'h00000000, 32'h0000ABCD, 48'h000000000001, 16'hABCD, 6'd47};
`else
        tbl[2] = '{32'h00000000, 32'h0000ABCD, 48'h000000000000, 16'hABCD, 6'd48};
`endif
        tbl[3] = '{32'h80000000, 32'h00000000, 48'h800000000000, 16'h0000, 6'd0};
        tbl[4] = '{32'h00000000, 32'h80000000, 48'h000000008000, 16'h0000, 6'd32};
        tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 16'hFFFF, 6'd0};
        tbl[6] = '{32'h00010000, 32'h00000000, 48'h000100000000, 16'h0000, 6'd15};
        tbl[7] = '{32'h00000001, 32'h12340000, 48'h000000011234, 16'h0000, 6'd31};

        // Reset state
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_u0",    64'(out_u0),    64'd0);
        chk("rst_u1",    64'(out_u1),    64'd0);
        chk("rst_lzc",   64'(out_lzc),   64'd0);
        chk("rst_drop",  64'(drop_cnt),  64'd0);

        // Vector table: each pair visible one cycle after its lo word
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, tbl[i].hi, 1'b1);
            cycle(1'b1, 1'b1, tbl[i].lo, 1'b1);
            chk("tbl_valid", 64'(out_valid), 64'd1);
            chk("tbl_u0",    64'(out_u0),    64'(tbl[i].u0));
            chk("tbl_u1",    64'(out_u1),    64'(tbl[i].u1));
            chk("tbl_lzc",   64'(out_lzc),   64'(tbl[i].lzc));
            chk("tbl_drop",  64'(drop_cnt),  64'd0);
        end
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("tbl_drain", 64'(out_valid), 64'd0);

        // Backpressure: P0,P1 kept, P2,P3 dropped
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 32'h11111111 * 32'(i + 1), 1'b0);
        chk("bp_drop",  64'(drop_cnt), 64'd2);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_p0_u0", 64'(out_u0), 64'h111111112222);
        chk("bp_p0_u1", 64'(out_u1), 64'h2222);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("bp_p1_u0", 64'(out_u0), 64'h333333334444);
        chk("bp_p1_u1", 64'(out_u1), 64'h4444);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_hold",  64'(out_u0), 64'h333333334444);

        // Gapped input
        cycle(1'b1, 1'b1, 32'hCAFEBABE, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'hFFFFFFFF, 1'b1);
        chk("gap_valid0", 64'(out_valid), 64'd0);
        cycle(1'b1, 1'b1, 32'h0F0F1234, 1'b1);
        chk("gap_u0",  64'(out_u0),  64'hCAFEBABE0F0F);
        chk("gap_u1",  64'(out_u1),  64'h1234);
        chk("gap_lzc", 64'(out_lzc), 64'd0);

        // Reset right after a hi word discards it
        cycle(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b1, 32'h00ABCDEF, 1'b1);
        chk("rhi_valid0", 64'(out_valid), 64'd0);
        cycle(1'b1, 1'b1, 32'h13579BDF, 1'b1);
        chk("rhi_valid", 64'(out_valid), 64'd1);
        chk("rhi_u0",  64'(out_u0),  64'h00ABCDEF1357);
        chk("rhi_u1",  64'(out_u1),  64'h9BDF);
        chk("rhi_lzc", 64'(out_lzc), 64'd8);

        // Full FIFO with continuous push and pop
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 32'h01000000 + 32'(i), 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, $urandom, 1'b1);
        chk("full_drop", 64'(drop_cnt), 64'd0);

        // Drop counter saturation on the narrow-counter instance
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 28; i++) cycle(1'b1, 1'b1, 32'h00000100, 1'b1);
        chk("sat_mid",   64'(drop_cnt2), 64'd10);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 32'h00000100, 1'b1);
        chk("sat_full",  64'(drop_cnt2), 64'd15);
        chk("sat_valid", 64'(out_valid2), 64'd1);
        chk("sat_u0",    64'(out_u0_2),  64'h000001000000);
        chk("sat_u1",    64'(out_u1_2),  64'h0100);
        chk("sat_lzc",   64'(out_lzc2),  64'd23);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            d = $urandom;
            case ($urandom_range(0, 7))
                0: d = 32'd0;
                1, 2: d = d >> $urandom_range(0, 31);
                default: ;
            endcase
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), d,
                  ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
